// File: rtl/barrido_controller.sv
`default_nettype none
// ============================================================================
// barrido_controller : sweeps every N_IN-bit input vector in ascending order,
// holding each for DWELL cycles, and collects x/y hit counts plus a MISR.
// Revision 1.0
// ============================================================================
module barrido_controller #(
   parameter int N_IN  = 6,
   parameter int DWELL = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            abort,
   output logic [N_IN-1:0] vec_o,
   input  logic            x_i,
   input  logic            y_i,
   output logic            busy,
   output logic            done,
   output logic            results_valid,
   output logic [N_IN:0]   cnt_x,
   output logic [N_IN:0]   cnt_y,
   output logic [7:0]      sig
);

   localparam int              DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
   localparam logic [DW_W-1:0] DW_ONE     = DW_W'(1);
   localparam logic [N_IN-1:0] VEC_LAST   = '1;
   localparam logic [N_IN-1:0] VEC_ONE    = N_IN'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [N_IN-1:0]   vec_q, vec_d;
   logic [DW_W-1:0]   dwell_q, dwell_d;
   logic [N_IN:0]     cnt_x_q, cnt_x_d;
   logic [N_IN:0]     cnt_y_q, cnt_y_d;
   logic [7:0]        sig_q, sig_d;
   logic              valid_q, valid_d;

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      dwell_d = dwell_q;
      cnt_x_d = cnt_x_q;
      cnt_y_d = cnt_y_q;
      sig_d   = sig_q;
      valid_d = valid_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               vec_d   = '0;
               dwell_d = '0;
               cnt_x_d = '0;
               cnt_y_d = '0;
               sig_d   = '0;
               valid_d = 1'b0;
            end
         end
         S_RUN: begin
            // Abort outranks a coincident sample edge; partial results stay invalid.
            if (abort) begin
               state_d = S_IDLE;
               vec_d   = '0;
               dwell_d = '0;
            end else if (dwell_q != DWELL_LAST) begin
               dwell_d = dwell_q + DW_ONE;
            end else begin
               cnt_x_d = cnt_x_q + {{N_IN{1'b0}}, x_i};
               cnt_y_d = cnt_y_q + {{N_IN{1'b0}}, y_i};
               sig_d   = {sig_q[6:0], sig_q[7]} ^ {6'b0, y_i, x_i};
               vec_d   = vec_q + VEC_ONE;
               dwell_d = '0;
               if (vec_q == VEC_LAST) begin
                  state_d = S_DONE;
                  valid_d = 1'b1;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         vec_q   <= '0;
         dwell_q <= '0;
         cnt_x_q <= '0;
         cnt_y_q <= '0;
         sig_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         dwell_q <= dwell_d;
         cnt_x_q <= cnt_x_d;
         cnt_y_q <= cnt_y_d;
         sig_q   <= sig_d;
         valid_q <= valid_d;
      end
   end

   assign vec_o         = vec_q;
   assign busy          = (state_q == S_RUN);
   assign done          = (state_q == S_DONE);
   assign results_valid = valid_q;
   assign cnt_x         = cnt_x_q;
   assign cnt_y         = cnt_y_q;
   assign sig           = sig_q;

endmodule
`default_nettype wire

// File: doc/barrido_controller.md
Name: barrido_controller

Overview:
- Exhaustive-stimulus sequencer for a small combinational block with 6 inputs (a..f) and 2 outputs (x, y).
- On request, it drives every input combination in ascending binary order and holds each one for a programmable number of clock cycles.
- It samples x/y once per vector and accumulates per-output hit counts plus an 8-bit MISR signature.
- It sits between a control source (button/FSM/bench) and the combinational datapath; vec_o wires straight to the datapath inputs.

Parameters:
- N_IN, 6, number of datapath inputs; sweep length 2^N_IN vectors.
- DWELL, 1, clock cycles each vector is held (>=1); the sample is taken on the last dwell cycle.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- start  input  1  level; sampled in IDLE only; launches a sweep
- abort  input  1  level; sampled in RUN only; terminates the sweep without done
- vec_o  output  N_IN  stimulus vector; bit N_IN-1 = a ... bit 0 = f
- x_i  input  1  datapath output x (combinational from vec_o)
- y_i  input  1  datapath output y
- busy  output  1  high while in RUN
- done  output  1  single-cycle pulse when the sweep completes
- results_valid  output  1  count/signature outputs hold a complete sweep result
- cnt_x  output  N_IN+1  number of vectors with x_i=1
- cnt_y  output  N_IN+1  number of vectors with y_i=1
- sig  output  8  MISR signature of (y_i, x_i) over the sweep

Behaviour:
- Reset (rst_n=0 at edge):
  - state=IDLE; vec_o=0, busy=0, done=0, results_valid=0, cnt_x=0, cnt_y=0, sig=0, dwell counter=0.
  - Reset has priority over all inputs, including mid-sweep.
- States:
  - IDLE -> RUN on start=1.
  - RUN -> DONE after the last sample.
  - RUN -> IDLE on abort=1.
  - DONE -> IDLE unconditionally after 1 cycle.
- Start accepted at edge k:
  - vec_o=0, cnt_x=0, cnt_y=0, sig=0, results_valid=0, busy=1, dwell counter=0.
- RUN, per edge:
  - If dwell counter < DWELL-1: increment the dwell counter.
  - Otherwise (sample edge):
    - cnt_x += x_i; cnt_y += y_i.
    - sig <= {sig[6:0], sig[7]} ^ {6'b0, y_i, x_i}.
    - vec_o increments modulo 2^N_IN; dwell counter=0.
- Sample edges:
  - Sample edges fall at k+DWELL*j, j=1..2^N_IN.
  - x_i/y_i are sampled for the vector present during the preceding cycle.
- Final sample edge (j=2^N_IN):
  - vec_o wraps to 0; state=DONE; busy=0, done=1, results_valid=1.
  - Latency from start edge to done: 2^N_IN*DWELL cycles.
- DONE:
  - done falls at the next edge; results hold until the next accepted start or reset.
- start while busy or in DONE: ignored. start held high in IDLE: retriggers a new sweep every pass.
- abort in RUN:
  - Next edge: IDLE, busy=0, vec_o=0, no done pulse, results_valid stays 0.
  - Partial cnt_x/cnt_y/sig are retained but invalid.
- abort and sample on the same edge: abort wins, and the sample is discarded.
- Width rules:
  - Counters are N_IN+1 bits, so the maximum 2^N_IN never overflows.
  - The dwell counter is wide enough for DWELL-1.
- vec_o is registered and changes only on sample edges, start, abort or reset. It is glitch-free relative to clk.

Test Plan:
- DWELL=1, x_i=vec_o[0], y_i=&vec_o; pulse start -> busy for 64 cycles, vec_o steps 0..63, done pulse 64 cycles after the start edge, cnt_x=32, cnt_y=1, results_valid=1, vec_o=0.
- x_i=&vec_o (x only on vector 63), y_i=0 -> cnt_x=1, cnt_y=0, sig=8'h01. Then x_i=0, y_i=(vec_o==0) -> cnt_y=1, sig=8'h01.
- DWELL=3, x_i=1, y_i=0 -> each vector held exactly 3 cycles, done at start+192, cnt_x=64, sig=8'h00.
- abort asserted at vector 10 -> busy=0 next edge, vec_o=0, no done pulse, results_valid=0, cnt_x=10 for x_i=1. A new start then completes normally.
- rst_n=0 mid-sweep (vector 20) -> all outputs at reset values on the following edge. start pulses during busy are ignored, with no timing change.
- start held high continuously -> back-to-back sweeps: done, 1 DONE cycle, IDLE, re-start. Each result set is valid in the cycle done=1.
